// File: rtl/pixel_word_packer.sv
// Packs the capture-stage byte stream into 32-bit words, tags the first
// word of every frame and buffers words in a small FIFO for the DMA writer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              when low, input pixels are ignored (flush still works)
//   pix_valid/pix_data  input pixel strobe and byte
//   frame_count         frame index of the current pixel
//   flush               emit the partial word held in the accumulator
//   clear               empty accumulator, zero drop_count, forget frame state
//   out_valid/out_ready valid/ready handshake on the FIFO head
//   out_data/keep/sof/frame  head word, byte mask, first-of-frame, frame index
//   fifo_level          occupied FIFO entries
//   drop_count          saturating count of words lost on a full FIFO
module pixel_word_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    input  logic [15:0]        frame_count,
    input  logic               flush,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [3:0]         out_keep,
    output logic               out_sof,
    output logic [15:0]        out_frame,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        drop_count
);

    typedef struct packed {
        logic [15:0] frame;
        logic        sof;
        logic [3:0]  keep;
        logic [31:0] data;
    } entry_t;

    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(FIFO_DEPTH);

    function automatic logic [3:0] keep_of(input logic [2:0] n);
        case (n)
            3'd1:    keep_of = 4'b0001;
            3'd2:    keep_of = 4'b0011;
            3'd3:    keep_of = 4'b0111;
            default: keep_of = 4'b1111;
        endcase
    endfunction

    // Packer state
    logic [31:0]      acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [15:0]      last_frame_q, last_frame_d;
    logic             frame_seen_q, frame_seen_d;
    logic             pend_sof_q, pend_sof_d;
    logic             flush_pend_q, flush_pend_d;
    logic [15:0]      drop_count_q, drop_count_d;

    // FIFO state
    entry_t           mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] level_q, level_d;
    entry_t           head_q, head_d;
    logic             out_valid_q, out_valid_d;

    logic             push;
    entry_t           push_e;
    logic             new_frame;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic [FIFO_AW:0] remain;

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        last_frame_d = last_frame_q;
        frame_seen_d = frame_seen_q;
        pend_sof_d   = pend_sof_q;
        flush_pend_d = flush_pend_q;
        drop_count_d = drop_count_q;
        push         = 1'b0;
        push_e       = '0;
        new_frame    = 1'b0;

        if (clear) begin
            acc_d        = '0;
            cnt_d        = '0;
            pend_sof_d   = 1'b0;
            flush_pend_d = 1'b0;
            frame_seen_d = 1'b0;
            drop_count_d = '0;
        end else begin
            // A flush deferred from last cycle goes ahead of this cycle's pixel
            if (flush_pend_q) begin
                flush_pend_d = 1'b0;
                if (cnt_d != 3'd0) begin
                    push        = 1'b1;
                    push_e.data = acc_d;
                    push_e.keep = keep_of(cnt_d);
                    push_e.sof  = pend_sof_d;
                    push_e.frame = last_frame_d;
                    acc_d       = '0;
                    cnt_d       = '0;
                    pend_sof_d  = 1'b0;
                end
            end

            if (enable && pix_valid) begin
                new_frame = !frame_seen_d || (frame_count != last_frame_d);
                if (new_frame) begin
                    // Close out the old frame's partial word first
                    if (cnt_d != 3'd0) begin
                        push         = 1'b1;
                        push_e.data  = acc_d;
                        push_e.keep  = keep_of(cnt_d);
                        push_e.sof   = pend_sof_d;
                        push_e.frame = last_frame_d;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end
                    last_frame_d = frame_count;
                    frame_seen_d = 1'b1;
                    pend_sof_d   = 1'b1;
                end
                acc_d[{cnt_d[1:0], 3'b000} +: 8] = pix_data;
                cnt_d = cnt_d + 3'd1;
                if (cnt_d == 3'd4) begin
                    push         = 1'b1;
                    push_e.data  = acc_d;
                    push_e.keep  = 4'b1111;
                    push_e.sof   = pend_sof_d;
                    push_e.frame = last_frame_d;
                    acc_d        = '0;
                    cnt_d        = '0;
                    pend_sof_d   = 1'b0;
                end
            end

            // Only one push per cycle: a second one is deferred a cycle
            if (flush && cnt_d != 3'd0) begin
                if (push) begin
                    flush_pend_d = 1'b1;
                end else begin
                    push         = 1'b1;
                    push_e.data  = acc_d;
                    push_e.keep  = keep_of(cnt_d);
                    push_e.sof   = pend_sof_d;
                    push_e.frame = last_frame_d;
                    acc_d        = '0;
                    cnt_d        = '0;
                    pend_sof_d   = 1'b0;
                end
            end
        end

        pop   = out_valid_q && out_ready;
        full  = (level_q == DEPTH_L);
        wr_en = push && (!full || pop);

        if (push && full && !pop) begin
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
            // Lost the frame tag: the next word that lands carries it
            if (push_e.sof) begin
                pend_sof_d = 1'b1;
            end
        end

        wr_ptr_d = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + (FIFO_AW + 1)'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - (FIFO_AW + 1)'(1);
        end

        // Next head: the incoming word if nothing else remains, else memory
        remain      = level_q - (FIFO_AW + 1)'(pop);
        out_valid_d = (level_d != '0);
        if (level_d == '0) begin
            head_d = '0;
        end else if (remain == '0) begin
            head_d = push_e;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            last_frame_q <= '0;
            frame_seen_q <= 1'b0;
            pend_sof_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            drop_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            head_q       <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            last_frame_q <= last_frame_d;
            frame_seen_q <= frame_seen_d;
            pend_sof_q   <= pend_sof_d;
            flush_pend_q <= flush_pend_d;
            drop_count_q <= drop_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            head_q       <= head_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = head_q.data;
    assign out_keep   = head_q.keep;
    assign out_sof    = head_q.sof;
    assign out_frame  = head_q.frame;
    assign fifo_level = level_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer: scoreboard of expected words
// plus per-scenario checks of level, drop count and reset behaviour.
module tb_pixel_word_packer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [15:0] frame_count;
    logic        flush;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_sof;
    logic [15:0] out_frame;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        s;
        logic [15:0] f;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks;
    int   failures;

    pixel_word_packer #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_count (frame_count),
        .flush       (flush),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_sof     (out_sof),
        .out_frame   (out_frame),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare each accepted head word against the queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra got data=%h keep=%h sof=%0b frame=%h expected none",
                         out_data, out_keep, out_sof, out_frame);
            end else begin
                e = q.pop_front();
                if ({out_data, out_keep, out_sof, out_frame} !== {e.d, e.k, e.s, e.f}) begin
                    failures++;
                    $display("FAIL sb_word got %h/%h/%0b/%h expected %h/%h/%0b/%h",
                             out_data, out_keep, out_sof, out_frame, e.d, e.k, e.s, e.f);
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k,
                               input logic s, input logic [15:0] f);
        exp_t x;
        x.d = d;
        x.k = k;
        x.s = s;
        x.f = f;
        q.push_back(x);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic [15:0] fc, input logic fl);
        pix_valid   = v;
        pix_data    = d;
        frame_count = fc;
        flush       = fl;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        pix_valid = 1'b0;
        flush     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_keep, out_sof, out_frame} !== 54'd0) begin
            failures++;
            $display("FAIL reset_out got v=%0b d=%h k=%h s=%0b f=%h expected all 0",
                     out_valid, out_data, out_keep, out_sof, out_frame);
        end
        checks++;
        if ({fifo_level, drop_count} !== 20'd0) begin
            failures++;
            $display("FAIL reset_cnt got level=%0d drop=%0d expected 0/0",
                     fifo_level, drop_count);
        end
    endtask

    task automatic test_basic();
        do_reset();
        expect_word(32'h44332211, 4'hF, 1'b1, 16'd5);
        cyc(1, 8'h11, 16'd5, 0);
        cyc(1, 8'h22, 16'd5, 0);
        cyc(1, 8'h33, 16'd5, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early got valid=%0b expected 0", out_valid);
        end
        cyc(1, 8'h44, 16'd5, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            failures++;
            $display("FAIL basic_latency got valid=%0b data=%h expected 1/44332211",
                     out_valid, out_data);
        end
        wait_drain();
        checks++;
        if (q.size() != 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL basic_drain got left=%0d level=%0d expected 0/0",
                     q.size(), fifo_level);
        end
    endtask

    task automatic test_frame_change();
        do_reset();
        expect_word(32'h44332211, 4'hF, 1'b1, 16'd5);
        expect_word(32'h00006655, 4'h3, 1'b0, 16'd5);
        expect_word(32'hDDCCBBAA, 4'hF, 1'b1, 16'd6);
        cyc(1, 8'h11, 16'd5, 0);
        cyc(1, 8'h22, 16'd5, 0);
        cyc(1, 8'h33, 16'd5, 0);
        cyc(1, 8'h44, 16'd5, 0);
        cyc(1, 8'h55, 16'd5, 0);
        cyc(1, 8'h66, 16'd5, 0);
        cyc(1, 8'hAA, 16'd6, 0);
        cyc(1, 8'hBB, 16'd6, 0);
        cyc(1, 8'hCC, 16'd6, 0);
        cyc(1, 8'hDD, 16'd6, 0);
        wait_drain();
        checks++;
        if (q.size() != 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL frame_drain got left=%0d level=%0d expected 0/0",
                     q.size(), fifo_level);
        end
    endtask

    task automatic test_flush();
        do_reset();
        expect_word(32'h00030201, 4'h7, 1'b1, 16'd7);
        expect_word(32'h00000504, 4'h3, 1'b0, 16'd7);
        expect_word(32'h00000006, 4'h1, 1'b1, 16'd8);
        cyc(1, 8'h01, 16'd7, 0);
        cyc(1, 8'h02, 16'd7, 0);
        cyc(1, 8'h03, 16'd7, 1);
        cyc(0, 8'h00, 16'd7, 1);
        cyc(1, 8'h04, 16'd7, 0);
        cyc(1, 8'h05, 16'd7, 0);
        cyc(1, 8'h06, 16'd8, 1);
        cyc(0, 8'h00, 16'd8, 0);
        cyc(0, 8'h00, 16'd8, 1);
        wait_drain();
        checks++;
        if (q.size() != 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL flush_drain got left=%0d level=%0d expected 0/0",
                     q.size(), fifo_level);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        expect_word(32'h13121110, 4'hF, 1'b1, 16'hFFFF);
        expect_word(32'h23222120, 4'hF, 1'b1, 16'h0000);
        for (int j = 0; j < 4; j++) cyc(1, 8'(8'h10 + j), 16'hFFFF, 0);
        for (int j = 0; j < 4; j++) cyc(1, 8'(8'h20 + j), 16'h0000, 0);
        wait_drain();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL wrap_drain got left=%0d expected 0", q.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                expect_word({8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)},
                            4'hF, (k == 0), 16'd9);
            end
            for (int j = 0; j < 4; j++) cyc(1, 8'(4*k+j+1), 16'd9, 0);
        end
        checks++;
        if (fifo_level !== 4'd8 || drop_count !== 16'd3) begin
            failures++;
            $display("FAIL ovf_full got level=%0d drop=%0d expected 8/3",
                     fifo_level, drop_count);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
            failures++;
            $display("FAIL ovf_hold got valid=%0b data=%h expected 1/04030201",
                     out_valid, out_data);
        end
        cyc(1, 8'd45, 16'd9, 0);
        cyc(1, 8'd46, 16'd9, 0);
        cyc(1, 8'd47, 16'd9, 0);
        expect_word(32'h302F2E2D, 4'hF, 1'b0, 16'd9);
        out_ready = 1'b1;
        cyc(1, 8'd48, 16'd9, 0);
        out_ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd8 || drop_count !== 16'd3) begin
            failures++;
            $display("FAIL full_pushpop got level=%0d drop=%0d expected 8/3",
                     fifo_level, drop_count);
        end
        checks++;
        if (out_data !== 32'h08070605) begin
            failures++;
            $display("FAIL full_head got data=%h expected 08070605", out_data);
        end
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (q.size() != 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL ovf_drain got left=%0d level=%0d expected 0/0",
                     q.size(), fifo_level);
        end
    endtask

    task automatic test_clear();
        cyc(1, 8'hA1, 16'd9, 0);
        cyc(1, 8'hA2, 16'd9, 0);
        clear = 1'b1;
        cyc(1, 8'hA3, 16'd9, 1);
        clear = 1'b0;
        checks++;
        if (drop_count !== 16'd0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL clear_state got drop=%0d level=%0d expected 0/0",
                     drop_count, fifo_level);
        end
        expect_word(32'hB4B3B2B1, 4'hF, 1'b1, 16'd9);
        for (int j = 0; j < 4; j++) cyc(1, 8'(8'hB1 + j), 16'd9, 0);
        wait_drain();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL clear_drain got left=%0d expected 0", q.size());
        end
    endtask

    task automatic test_enable();
        do_reset();
        expect_word(32'h00000201, 4'h3, 1'b1, 16'd3);
        cyc(1, 8'h01, 16'd3, 0);
        cyc(1, 8'h02, 16'd3, 0);
        enable = 1'b0;
        cyc(1, 8'h03, 16'd3, 0);
        cyc(1, 8'h04, 16'd3, 1);
        wait_drain();
        enable = 1'b1;
        checks++;
        if (q.size() != 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL enable_drain got left=%0d level=%0d expected 0/0",
                     q.size(), fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int j = 0; j < 6; j++) cyc(1, 8'(8'h50 + j), 16'd4, 0);
        checks++;
        if (fifo_level !== 4'd1) begin
            failures++;
            $display("FAIL mid_level got %0d expected 1", fifo_level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_keep, out_sof, out_frame,
             fifo_level, drop_count} !== 74'd0) begin
            failures++;
            $display("FAIL mid_reset got v=%0b d=%h level=%0d expected all 0",
                     out_valid, out_data, fifo_level);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        expect_word(32'hC4C3C2C1, 4'hF, 1'b1, 16'd4);
        for (int j = 0; j < 4; j++) cyc(1, 8'(8'hC1 + j), 16'd4, 0);
        wait_drain();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL mid_drain got left=%0d expected 0", q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 8'd0;
        frame_count = 16'd0;
        flush       = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_frame_change();
        test_flush();
        test_wrap();
        test_overflow();
        test_clear();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Sits directly downstream of the camera capture stage.
- Consumes its registered byte stream (pix_valid, pix_data, frame_count) and packs four 8-bit pixels into 32-bit words.
- Tags the first word of each frame and buffers words in a small FIFO with a valid/ready output towards the frame-buffer DMA writer.
- Counts words lost to FIFO overflow, because the capture side cannot be back-pressured.

Parameters:
FIFO_DEPTH, 8, number of 53-bit entries (32 data + 4 keep + 1 sof + 16 frame); power of two, >= 2
FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  packer enable; when low, input pixels are ignored
pix_valid  input  1  input pixel strobe
pix_data  input  8  input pixel
frame_count  input  16  frame index from capture stage, stable or incrementing with pix_valid
flush  input  1  single-cycle request to emit a partial word (end of line/frame)
clear  input  1  synchronous clear of drop_count and of the packer state (FIFO contents kept)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head when out_valid && out_ready
out_data  output  32  packed word; first pixel in [7:0], fourth in [31:24]
out_keep  output  4  byte-valid mask, bit i = byte i valid; always contiguous from bit 0
out_sof  output  1  word is first of a frame
out_frame  output  16  frame_count of the word's pixels
fifo_level  output  FIFO_AW+1  occupied entries, 0..FIFO_DEPTH
drop_count  output  16  saturating count of words dropped on full FIFO

Behaviour:
- Reset (async):
  - All outputs 0.
  - Accumulator empty (byte index 0); frame_seen = 0; pending_sof = 0; flush_pend = 0; FIFO empty.
- Accepted pixel: enable && pix_valid.
- New-frame detection on accepted pixel: frame_seen == 0, or frame_count != last_frame.
  - On detection: last_frame <= frame_count, frame_seen <= 1, pending_sof <= 1.
- Boundary flush: new-frame pixel arrives with accumulator holding 1-3 bytes.
  - The partial word (old frame, its keep, its sof flag) is pushed.
  - The new pixel becomes byte 0 of a fresh accumulator in the same cycle.
- Normal pixel: written into byte index; index increments.
  - Reaching 4 pushes the word (keep = 4'b1111, sof = pending_sof, frame = last_frame); index returns to 0.
  - pending_sof is cleared on that push.
- Flush handling:
  - Evaluated after the same-cycle pixel.
  - If the accumulator is then non-empty, push with keep = (1<<count)-1 and clear the accumulator.
  - Flush on an empty accumulator: no push.
  - Flush in a cycle that already pushes a boundary-flush word sets flush_pend; the flush is applied the next cycle, before that cycle's pixel.
- Push rate: at most one push per cycle by construction.
- Unused bytes of a partial word are 0.
- FIFO:
  - Synchronous, registered outputs from head entry.
  - Push and pop in the same cycle allowed at any level, including full: pop frees the slot and the push succeeds.
  - Read latency: a word pushed into an empty FIFO shows out_valid on the next cycle.
- Overflow: a push while full with no pop drops the word and increments drop_count, saturating at 16'hFFFF.
  - If the dropped word carried sof, pending_sof is re-armed so the next pushed word is tagged.
- Output hold: out_data/keep/sof/frame hold stable while out_valid && !out_ready.
- fifo_level updates the cycle after push/pop.
- enable low:
  - Pixels ignored; flush still honoured.
  - Output side keeps draining.
- clear: empties the accumulator, zeros drop_count, clears pending_sof, flush_pend and frame_seen.
  - Same-cycle pixel is ignored.
- frame_count wrap (FFFF->0000) is a normal change (new frame).

Test Plan:
- Reset, frame_count=5, pixels 11,22,33,44 consecutive -> one word out_data=32'h44332211, keep=F, sof=1, frame=5, out_valid one cycle after 4th pixel.
- 6 pixels frame 5 then pixel AA with frame_count=6 -> words 0x44332211 (sof=1), 0x00006655 keep=3 sof=0 frame=5, then AA starts frame 6; after 3 more pixels word has sof=1, frame=6.
- 2 pixels then flush with a pixel in the same cycle -> word keep=7 (3 bytes); flush with empty accumulator -> no word.
- out_ready=0, push FIFO_DEPTH+3 full words -> fifo_level=8, drop_count=3, out_data stays first word; then out_ready=1 -> 8 words in order.
- Full FIFO, push and pop same cycle -> drop_count unchanged, level stays 8.
- rst_n low mid-word with FIFO non-empty -> all outputs 0 immediately; first pixel after reset tagged sof.
